// File: rtl/seq_div16by8.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient and remainder.
// One quotient bit per BUSY cycle, valid/ready on both sides, divide-by-zero and overflow flags.
module seq_div16by8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dat_in_a,
    input  logic [7:0]  dat_in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  quo_o,
    output logic [7:0]  rem_o,
    output logic        dz_o,
    output logic        ovf_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    // The 9-bit partial remainder always satisfies r < d, so only its low byte is stored.
    logic [7:0] r_q, r_d;
    logic [7:0] s_q, s_d;
    logic [7:0] d_q, d_d;
    logic [2:0] cnt_q, cnt_d;
    logic       scdz_q, scdz_d;
    logic       scovf_q, scovf_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
    logic       dz_q, dz_d;
    logic       ovf_q, ovf_d;

    logic [8:0] t;
    logic       qbit;
    logic [7:0] r_step;
    logic [7:0] s_step;

    assign t      = {r_q, s_q[7]};
    assign qbit   = (t >= {1'b0, d_q});
    assign r_step = qbit ? 8'(t - {1'b0, d_q}) : t[7:0];
    assign s_step = {s_q[6:0], qbit};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        s_d     = s_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        scdz_d  = scdz_q;
        scovf_d = scovf_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Shortcut results park for one BUSY cycle so they surface one edge after accept.
                    state_d = ST_BUSY;
                    d_d     = dat_in_b;
                    cnt_d   = 3'd0;
                    if (dat_in_b == 8'd0) begin
                        scdz_d  = 1'b1;
                        scovf_d = 1'b0;
                        r_d     = dat_in_a[7:0];
                        s_d     = 8'hFF;
                    end else if (dat_in_a[15:8] >= dat_in_b) begin
                        scdz_d  = 1'b0;
                        scovf_d = 1'b1;
                        r_d     = 8'hFF;
                        s_d     = 8'hFF;
                    end else begin
                        scdz_d  = 1'b0;
                        scovf_d = 1'b0;
                        r_d     = dat_in_a[15:8];
                        s_d     = dat_in_a[7:0];
                    end
                end
            end
            ST_BUSY: begin
                if (scdz_q || scovf_q) begin
                    state_d = ST_DONE;
                    quo_d   = s_q;
                    rem_d   = r_q;
                    dz_d    = scdz_q;
                    ovf_d   = scovf_q;
                end else begin
                    r_d   = r_step;
                    s_d   = s_step;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_DONE;
                        quo_d   = s_step;
                        rem_d   = r_step;
                        dz_d    = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= 8'd0;
            s_q     <= 8'd0;
            d_q     <= 8'd0;
            cnt_q   <= 3'd0;
            scdz_q  <= 1'b0;
            scovf_q <= 1'b0;
            quo_q   <= 8'd0;
            rem_q   <= 8'd0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            s_q     <= s_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            scdz_q  <= scdz_d;
            scovf_q <= scovf_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && rst_n;
    assign out_valid = (state_q == ST_DONE);
    assign quo_o     = quo_q;
    assign rem_o     = rem_q;
    assign dz_o      = dz_q;
    assign ovf_o     = ovf_q;
endmodule
